// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge detector: RGB888 raster in, 8-bit edge magnitude out.
// Two-cycle fixed latency; gaps in HSYNC simply bubble through the pipeline.
module sobel_edge_stream #(
  parameter int WIDTH     = 768,
  parameter int HEIGHT    = 512,
  parameter int THRESHOLD = 0
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       HSYNC,
  input  logic [7:0] DATA_R0,
  input  logic [7:0] DATA_G0,
  input  logic [7:0] DATA_B0,
  output logic       EDGE_VALID,
  output logic [7:0] EDGE_DATA,
  output logic       FRAME_DONE
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic [15:0] luma_sum;
  logic [7:0]  y_next;

  logic          s0_valid;
  logic [7:0]    s0_y;
  logic [CW-1:0] s0_col;
  logic [RW-1:0] s0_row;

  logic [7:0] lb1 [WIDTH];
  logic [7:0] lb2 [WIDTH];

  logic [7:0] win [3][3];
  logic       s1_valid;
  logic       s1_last;

  logic [9:0]  gx_pos, gx_neg, gy_pos, gy_neg;
  logic [9:0]  gx_abs, gy_abs;
  logic [10:0] mag;
  logic [7:0]  sat;
  logic [7:0]  edge_val;

  always_comb begin
    luma_sum = 16'd77 * 16'(DATA_R0) + 16'd150 * 16'(DATA_G0) + 16'd29 * 16'(DATA_B0);
    y_next   = 8'(luma_sum >> 8);
  end

  // Stage 0: raster position tracking and luma register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      col      <= '0;
      row      <= '0;
      s0_valid <= 1'b0;
      s0_y     <= '0;
      s0_col   <= '0;
      s0_row   <= '0;
    end else begin
      s0_valid <= HSYNC;
      if (HSYNC) begin
        s0_y   <= y_next;
        s0_col <= col;
        s0_row <= row;
        if (col == CW'(WIDTH - 1)) begin
          col <= '0;
          row <= (row == RW'(HEIGHT - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Line buffers hold the two previous rows; left unreset, row gating hides stale data.
  always_ff @(posedge HCLK) begin
    if (s0_valid) begin
      lb1[s0_col] <= s0_y;
      lb2[s0_col] <= lb1[s0_col];
    end
  end

  // Stage 1: shift one new column into the window.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          win[r][c] <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= s0_valid && (s0_row >= RW'(2)) && (s0_col >= CW'(2));
      s1_last  <= (s0_row == RW'(HEIGHT - 1)) && (s0_col == CW'(WIDTH - 1));
      if (s0_valid) begin
        for (int unsigned r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb2[s0_col];
        win[1][2] <= lb1[s0_col];
        win[2][2] <= s0_y;
      end
    end
  end

  // Absolute values taken as unsigned differences of the positive and negative taps.
  always_comb begin
    gx_pos = 10'(win[0][2]) + 10'({win[1][2], 1'b0}) + 10'(win[2][2]);
    gx_neg = 10'(win[0][0]) + 10'({win[1][0], 1'b0}) + 10'(win[2][0]);
    gy_pos = 10'(win[2][0]) + 10'({win[2][1], 1'b0}) + 10'(win[2][2]);
    gy_neg = 10'(win[0][0]) + 10'({win[0][1], 1'b0}) + 10'(win[0][2]);
    gx_abs = (gx_pos >= gx_neg) ? gx_pos - gx_neg : gx_neg - gx_pos;
    gy_abs = (gy_pos >= gy_neg) ? gy_pos - gy_neg : gy_neg - gy_pos;
    mag    = 11'(gx_abs) + 11'(gy_abs);
    sat    = (mag > 11'd255) ? 8'hFF : mag[7:0];
    if (THRESHOLD == 0)
      edge_val = sat;
    else
      edge_val = (int'(sat) > THRESHOLD) ? 8'hFF : 8'h00;
  end

  // Stage 2: registered outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      EDGE_VALID <= 1'b0;
      EDGE_DATA  <= '0;
      FRAME_DONE <= 1'b0;
    end else begin
      EDGE_VALID <= s1_valid;
      EDGE_DATA  <= s1_valid ? edge_val : '0;
      FRAME_DONE <= s1_valid && s1_last;
    end
  end

endmodule

// File: tb/tb_sobel_edge_stream.sv
// Randomized and directed bench for sobel_edge_stream against an image-array reference model.
// Three instances share the stimulus to cover raw and two binarizing thresholds.
module tb_sobel_edge_stream;

  localparam int W = 8;
  localparam int H = 6;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       HSYNC;
  logic [7:0] DATA_R0, DATA_G0, DATA_B0;
  logic       v0, v1, v2, fd0, fd1, fd2;
  logic [7:0] d0, d1, d2;

  always #5 HCLK = ~HCLK;

  sobel_edge_stream #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(0)) dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSYNC(HSYNC),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
    .EDGE_VALID(v0), .EDGE_DATA(d0), .FRAME_DONE(fd0));

  sobel_edge_stream #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(30)) dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSYNC(HSYNC),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
    .EDGE_VALID(v1), .EDGE_DATA(d1), .FRAME_DONE(fd1));

  sobel_edge_stream #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(50)) dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSYNC(HSYNC),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
    .EDGE_VALID(v2), .EDGE_DATA(d2), .FRAME_DONE(fd2));

  typedef struct {
    int cyc;
    int e0, e1, e2;
    bit fd;
  } exp_t;

  exp_t q[$];
  int   img [H][W];
  int   mr, mc;
  int   cyc;
  int   n_checks, n_errors;
  int   n_valid, n_fd;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int bin(input int s, input int t);
    if (t == 0) return s;
    return (s > t) ? 255 : 0;
  endfunction

  // Magnitude for the window whose newest pixel is (r, c).
  function automatic int sobel(input int r, input int c);
    int p [3][3];
    int gx, gy, m;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = img[r - 2 + i][c - 2 + j];
    gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
    gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
    m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  task automatic model_accept(input logic [23:0] rgb);
    exp_t e;
    int   s;
    img[mr][mc] = (77 * int'(rgb[23:16]) + 150 * int'(rgb[15:8]) + 29 * int'(rgb[7:0])) / 256;
    if (mr >= 2 && mc >= 2) begin
      s     = sobel(mr, mc);
      e.cyc = cyc + 2;
      e.e0  = bin(s, 0);
      e.e1  = bin(s, 30);
      e.e2  = bin(s, 50);
      e.fd  = (mr == H - 1) && (mc == W - 1);
      q.push_back(e);
    end
    if (mc == W - 1) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    if (v0) n_valid++;
    if (fd0) n_fd++;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      check_eq("valid0", int'(v0), 1);
      check_eq("data0", int'(d0), e.e0);
      check_eq("frame_done0", int'(fd0), int'(e.fd));
      check_eq("valid_t30", int'(v1), 1);
      check_eq("data_t30", int'(d1), e.e1);
      check_eq("data_t50", int'(d2), e.e2);
      check_eq("frame_done_t50", int'(fd2), int'(e.fd));
    end else begin
      check_eq("idle_valid0", int'(v0), 0);
      check_eq("idle_data0", int'(d0), 0);
      check_eq("idle_frame_done0", int'(fd0), 0);
      check_eq("idle_valid_t30", int'(v1), 0);
      check_eq("idle_data_t30", int'(d1), 0);
      check_eq("idle_valid_t50", int'(v2), 0);
      check_eq("idle_data_t50", int'(d2), 0);
    end
  endtask

  task automatic step(input logic hs, input logic [23:0] rgb, input logic rstn);
    @(negedge HCLK);
    HSYNC   = hs;
    {DATA_R0, DATA_G0, DATA_B0} = rgb;
    HRESETn = rstn;
    if (!rstn) begin
      q.delete();
      mr = 0;
      mc = 0;
      #1 check_outputs();
    end
    @(posedge HCLK);
    cyc++;
    if (hs && rstn) model_accept(rgb);
    #1 check_outputs();
  endtask

  function automatic logic [23:0] pixel(input int kind, input int c);
    case (kind)
      0:       return {3{8'd100}};
      1:       return (c < 4) ? 24'h000000 : 24'hFFFFFF;
      2:       return (c < 4) ? {3{8'd10}} : {3{8'd20}};
      3:       return 24'hFF0000;
      4:       return 24'h000000;
      default: return 24'($urandom);
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) step(1'b0, 24'($urandom), 1'b1);
  endtask

  // gap: 0 continuous, 1 HSYNC toggling, 2 random idle bursts
  task automatic send_pixels(input int kind, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      step(1'b1, pixel(kind, i % W), 1'b1);
      if (gap == 1) idle(1);
      if (gap == 2 && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
  endtask

  task automatic frame_test(input string tag, input int kind, input int gap, input int frames);
    n_valid = 0;
    n_fd    = 0;
    for (int f = 0; f < frames; f++) send_pixels(kind, W * H, gap);
    idle(4);
    check_eq({tag, "_count"}, n_valid, frames * (H - 2) * (W - 2));
    check_eq({tag, "_frame_done"}, n_fd, frames);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0;
    HSYNC   = 1'b0;
    {DATA_R0, DATA_G0, DATA_B0} = '0;
    cyc = 0; n_checks = 0; n_errors = 0; mr = 0; mc = 0;
    repeat (3) step(1'b1, 24'($urandom), 1'b0);

    frame_test("flat_grey", 0, 0, 1);
    frame_test("vstep", 1, 0, 1);
    frame_test("grey_step", 2, 0, 1);
    frame_test("pure_red", 3, 0, 1);
    frame_test("vstep_toggle", 1, 1, 1);

    send_pixels(5, 20, 0);
    repeat (3) step(1'b1, 24'($urandom), 1'b0);
    frame_test("after_reset", 5, 0, 1);

    n_valid = 0;
    n_fd    = 0;
    send_pixels(4, W * H, 0);
    send_pixels(1, W * H, 0);
    idle(4);
    check_eq("b2b_count", n_valid, 2 * (H - 2) * (W - 2));
    check_eq("b2b_frame_done", n_fd, 2);

    frame_test("random_gaps", 5, 2, 4);
    frame_test("random_cont", 5, 0, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
